// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 8-bit rotator.
// The rotated result sits in a single output register (IDLE/FULL) that can
// drain and refill on the same edge, so back-to-back requests see no bubble.
module barrel_shift_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_data,
    input  logic [2:0] req0_n,
    input  logic       req0_lr,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_data,
    input  logic [2:0] req1_n,
    input  logic       req1_lr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_id,
    output logic [7:0] ops_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic        can_accept;
    logic        grant;
    logic        accept;
    logic [7:0]  op_data;
    logic [2:0]  op_n;
    logic        op_lr;
    logic [15:0] dd;
    logic [15:0] dd_left;
    logic [15:0] dd_right;
    logic [7:0]  rot_data;

    assign rsp_valid = (state_q == FULL);

    // Round-robin grant and combinational ready; nothing is granted during reset.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        can_accept = 1'b0;
        grant      = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        can_accept = !rst && ((state_q == IDLE) || rsp_ready);
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~req0_valid;
        end
        accept     = can_accept && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    // Operand mux feeding the single shared rotator.
    always_comb begin
        op_data  = grant ? req1_data : req0_data;
        op_n     = grant ? req1_n    : req0_n;
        op_lr    = grant ? req1_lr   : req0_lr;
        // Doubling the word lets a plain shift wrap bits around; n = 0 passes through.
        dd       = {op_data, op_data};
        dd_left  = dd << op_n;
        dd_right = dd >> op_n;
        rot_data = op_lr ? dd_left[15:8] : dd_right[7:0];
    end

    // Next state: fill on accept, drain to IDLE only when consumed with nothing new.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = FULL;
            end
            FULL: begin
                if (rsp_ready && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register, grant history and transfer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data     <= 8'h00;
            rsp_id       <= 1'b0;
            last_grant_q <= 1'b1;
            ops_cnt      <= 8'h00;
        end else begin
            if (accept) begin
                rsp_data     <= rot_data;
                rsp_id       <= grant;
                last_grant_q <= grant;
            end
            if (rsp_valid && rsp_ready) begin
                ops_cnt <= ops_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for barrel_shift_arbiter: a cycle model predicts readies,
// grants and the counter; expected results go into a scoreboard queue on
// accept and are compared while the DUT holds them.
module tb_barrel_shift_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_lr;
    logic [7:0] req0_data;
    logic [2:0] req0_n;
    logic       req1_valid, req1_ready, req1_lr;
    logic [7:0] req1_data;
    logic [2:0] req1_n;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data, ops_cnt;

    int   errors = 0;
    int   checks = 0;
    rsp_t sb_q[$];

    // Reference model state.
    logic       m_full = 1'b0;
    logic       m_last = 1'b1;
    logic [7:0] m_cnt  = 8'h00;
    logic       m_after_rst = 1'b0;

    always #5 clk = ~clk;

    barrel_shift_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_n     (req0_n),
        .req0_lr    (req0_lr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_n     (req1_n),
        .req1_lr    (req1_lr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .ops_cnt    (ops_cnt)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit rotation, written independently of the RTL shift trick.
    function automatic logic [7:0] rot(input logic [7:0] d, input logic [2:0] n, input logic lr);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (lr) r[(i + int'(n)) % 8] = d[i];
            else    r[i] = d[(i + int'(n)) % 8];
        end
        return r;
    endfunction

    // Drive one cycle of inputs, check at the falling edge, advance the model.
    task automatic step(input logic r,
                        input logic v0, input logic [7:0] d0, input logic [2:0] n0, input logic lr0,
                        input logic v1, input logic [7:0] d1, input logic [2:0] n1, input logic lr1,
                        input logic rr);
        logic can, g, acc;
        rsp_t e;
        rst = r;
        req0_valid = v0; req0_data = d0; req0_n = n0; req0_lr = lr0;
        req1_valid = v1; req1_data = d1; req1_n = n1; req1_lr = lr1;
        rsp_ready = rr;
        @(negedge clk);
        can = !r && (!m_full || rr);
        g   = (v0 && v1) ? ~m_last : ~v0;
        acc = can && (v0 || v1);
        check("req0_ready", {7'b0, req0_ready}, {7'b0, acc && !g});
        check("req1_ready", {7'b0, req1_ready}, {7'b0, acc && g});
        check("rsp_valid", {7'b0, rsp_valid}, {7'b0, m_full});
        check("ops_cnt", ops_cnt, m_cnt);
        if (m_after_rst) begin
            check("rst_rsp_data", rsp_data, 8'h00);
            check("rst_rsp_id", {7'b0, rsp_id}, 8'h00);
        end
        if (m_full) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: observed rsp_valid=1 expected a queued result");
            end else begin
                check("rsp_data", rsp_data, sb_q[0].data);
                check("rsp_id", {7'b0, rsp_id}, {7'b0, sb_q[0].id});
            end
        end
        if (r) begin
            m_full = 1'b0;
            m_last = 1'b1;
            m_cnt  = 8'h00;
            sb_q.delete();
            m_after_rst = 1'b1;
        end else begin
            m_after_rst = 1'b0;
            if (m_full && rr) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                m_cnt = m_cnt + 8'd1;
            end
            if (acc) begin
                e.id   = g;
                e.data = g ? rot(d1, n1, lr1) : rot(d0, n0, lr0);
                sb_q.push_back(e);
                m_last = g;
                m_full = 1'b1;
            end else if (m_full && rr) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, rr);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00; req0_n = 3'd0; req0_lr = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_n = 3'd0; req1_lr = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with requests pending: no readies, registers cleared.
        step(1'b1, 1'b1, 8'hAA, 3'd1, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Single left rotate from requester 0, then drain; rsp_ready in IDLE is ignored.
        idle(1'b1);
        step(1'b0, 1'b1, 8'b10110011, 3'd3, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Right rotate and n = 0 from requester 1, back to back.
        step(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'b10110011, 3'd2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'b11110000, 3'd0, 1'b0, 1'b1);
        idle(1'b1);

        // Contention right after reset: grants alternate starting with requester 0.
        step(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h81 + 8'(i), 3'(i), 1'b1, 1'b1, 8'h3C + 8'(i), 3'(i + 1), 1'b0, 1'b1);
        end
        idle(1'b1);

        // Backpressure: fill, hold three cycles, release with a same-cycle refill.
        step(1'b0, 1'b1, 8'hC5, 3'd5, 1'b1, 1'b1, 8'h1E, 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'hD9, 3'd4, 1'b0, 1'b1, 8'h1E, 3'd7, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 8'hD9, 3'd4, 1'b0, 1'b1, 8'h1E, 3'd7, 1'b0, 1'b1);
        idle(1'b1);

        // Counter wrap: 256 more transfers bring ops_cnt back to its current value.
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 8'(i * 7), 3'(i), 1'(i), 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        end
        idle(1'b1);
        idle(1'b0);

        // Reset while FULL under backpressure, then contention grants requester 0 first.
        step(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h96, 3'd3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h69, 3'd6, 1'b0, 1'b1, 8'h96, 3'd3, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h69, 3'd6, 1'b0, 1'b1, 8'h96, 3'd3, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and shift amount at 3 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_data  input  8  requester 0 operand.
REQ-007 req0_n  input  3  requester 0 rotate amount, 0..7.
REQ-008 req0_lr  input  1  requester 0 direction: 1 = rotate left, 0 = rotate right.
REQ-009 req1_valid, req1_ready, req1_data, req1_n, req1_lr SHALL mirror REQ-004..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  result register holds an unconsumed result.
REQ-011 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-012 rsp_data  output  8  rotated result.
REQ-013 rsp_id  output  1  requester index the result belongs to.
REQ-014 ops_cnt  output  8  count of completed response transfers, wraps 255 -> 0.

Function
REQ-015 The block SHALL contain one shared combinational 8-bit rotator: left rotates data by n toward MSB, right toward LSB, with bits wrapping around and n = 0 passing data unchanged.
REQ-016 FSM states SHALL be IDLE (rsp_valid = 0) and FULL (rsp_valid = 1).
REQ-017 The block SHALL be able to accept a request when in IDLE, or when in FULL with rsp_ready = 1 (same-cycle drain and refill).
REQ-018 Accept rule: when able to accept, at most one reqX_ready SHALL be 1, and only for a requester whose valid is 1; ready is combinational from the valids, state and rsp_ready.
REQ-019 Arbitration SHALL be round-robin: if both valids = 1, grant the requester other than last_grant; if one valid = 1, grant it.
REQ-020 last_grant SHALL update to the granted index only on an accepted transfer.
REQ-021 On accept at edge t, rsp_data SHALL equal the rotation of the granted operands, rsp_id the granted index, and rsp_valid = 1 from cycle t+1 (latency 1 cycle).
REQ-022 In FULL with rsp_ready = 0, rsp_data and rsp_id SHALL hold, and both reqX_ready SHALL be 0.
REQ-023 In FULL with rsp_ready = 1 and no accept, the state SHALL go to IDLE and rsp_valid to 0.
REQ-024 In FULL with rsp_ready = 1 and an accept, the state SHALL stay FULL with the new result loaded; no bubble.
REQ-025 ops_cnt SHALL increment by 1 on every cycle with rsp_valid = 1 and rsp_ready = 1, and wrap 255 -> 0.
REQ-026 Request inputs SHALL be ignored (not sampled) when the requester's ready = 0; the requester holds its operands until ready.
REQ-027 rsp_ready SHALL be ignored while rsp_valid = 0.

Reset
REQ-028 rst = 1 at a rising edge SHALL force: state IDLE, rsp_valid = 0, rsp_data = 8'h00, rsp_id = 0, ops_cnt = 0, last_grant = 1 (requester 0 wins the first contention).
REQ-029 Reset mid-operation SHALL discard any held result without a transfer, and both reqX_ready SHALL be 0 while rst = 1.

Verification
REQ-030 Single request: req0 data = 8'b10110011, n = 3, lr = 1, rsp_ready = 1 -> one cycle later rsp_valid = 1, rsp_data = 8'b10011101, rsp_id = 0, and ops_cnt = 1 after the transfer.
REQ-031 Right rotate and n = 0: req1 data = 8'b10110011, n = 2, lr = 0 -> rsp_data = 8'b11101100; data = 8'b11110000, n = 0 -> rsp_data = 8'b11110000.
REQ-032 Contention after reset: both valid continuously, rsp_ready = 1 -> grants alternate 0,1,0,1 with rsp_id following, one result per cycle, no bubble.
REQ-033 Backpressure: rsp_ready = 0 for 3 cycles while FULL -> rsp_data, rsp_id stable, both ready = 0, ops_cnt unchanged; on release, the next request is accepted in the same cycle.
REQ-034 Wrap: 256 transfers -> ops_cnt returns to 0.
REQ-035 Reset while FULL with rsp_ready = 0 -> next cycle rsp_valid = 0, ops_cnt = 0, and a subsequent simultaneous request grants requester 0 first.
